// File: rtl/bp_cce_pending_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_pending_mp_if
// Purpose  : Request/read bundle for the CCE multi-port pending-count table.
// Revision : 1.0 - initial release
// ============================================================================
interface bp_cce_pending_mp_if #(
    parameter int NUM_WAY_GROUPS_P = 8,
    parameter int WIDTH_P          = 3,
    parameter int NUM_RD_PORTS_P   = 2
);
    localparam int LG_NUM_WAY_GROUPS_LP = (NUM_WAY_GROUPS_P > 1) ? $clog2(NUM_WAY_GROUPS_P) : 1;

    logic                                             inc_v_i;
    logic [LG_NUM_WAY_GROUPS_LP-1:0]                  inc_way_group_i;
    logic                                             dec_v_i;
    logic [LG_NUM_WAY_GROUPS_LP-1:0]                  dec_way_group_i;
    logic                                             clr_v_i;
    logic [LG_NUM_WAY_GROUPS_LP-1:0]                  clr_way_group_i;
    logic [NUM_RD_PORTS_P-1:0]                        r_v_i;
    logic [NUM_RD_PORTS_P*LG_NUM_WAY_GROUPS_LP-1:0]   r_way_group_i;
    logic                                             err_clr_i;
    logic [NUM_RD_PORTS_P-1:0]                        pending_o;
    logic [NUM_RD_PORTS_P*WIDTH_P-1:0]                count_o;
    logic [NUM_RD_PORTS_P-1:0]                        pending_v_o;
    logic                                             any_pending_o;
    logic                                             overflow_o;
    logic                                             underflow_o;

    modport master (
        output inc_v_i, inc_way_group_i, dec_v_i, dec_way_group_i,
               clr_v_i, clr_way_group_i, r_v_i, r_way_group_i, err_clr_i,
        input  pending_o, count_o, pending_v_o, any_pending_o, overflow_o, underflow_o
    );

    modport slave (
        input  inc_v_i, inc_way_group_i, dec_v_i, dec_way_group_i,
               clr_v_i, clr_way_group_i, r_v_i, r_way_group_i, err_clr_i,
        output pending_o, count_o, pending_v_o, any_pending_o, overflow_o, underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/bp_cce_pending_mp.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_pending_mp
// Purpose  : Saturating per-way-group pending counters with separate inc/dec/
//            clr write ports, N combinational read ports and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module bp_cce_pending_mp #(
    parameter int NUM_WAY_GROUPS_P = 8,
    parameter int WIDTH_P          = 3,
    parameter int NUM_RD_PORTS_P   = 2,
    parameter bit BYPASS_P         = 1'b1
) (
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    bp_cce_pending_mp_if.slave bus
);
    localparam int LG_NUM_WAY_GROUPS_LP = (NUM_WAY_GROUPS_P > 1) ? $clog2(NUM_WAY_GROUPS_P) : 1;
    localparam logic [WIDTH_P-1:0] c_max_count = '1;

    logic [NUM_WAY_GROUPS_P-1:0][WIDTH_P-1:0] r_count;
    logic [NUM_WAY_GROUPS_P-1:0][WIDTH_P-1:0] w_count_next;
    logic [NUM_WAY_GROUPS_P-1:0]              w_ovf_evt;
    logic [NUM_WAY_GROUPS_P-1:0]              w_udf_evt;
    logic                                     r_overflow;
    logic                                     r_underflow;

    // Out-of-range write indices match no group and are therefore dropped.
    generate
        for (genvar g = 0; g < NUM_WAY_GROUPS_P; g++) begin : g_group
            logic               w_inc;
            logic               w_dec;
            logic               w_clr;
            logic [WIDTH_P-1:0] w_next;
            logic               w_ovf;
            logic               w_udf;
            logic [WIDTH_P-1:0] r_cnt;

            assign w_inc = bus.inc_v_i && (bus.inc_way_group_i == LG_NUM_WAY_GROUPS_LP'(g));
            assign w_dec = bus.dec_v_i && (bus.dec_way_group_i == LG_NUM_WAY_GROUPS_LP'(g));
            assign w_clr = bus.clr_v_i && (bus.clr_way_group_i == LG_NUM_WAY_GROUPS_LP'(g));

            always_comb begin
                w_next = r_cnt;
                w_ovf  = 1'b0;
                w_udf  = 1'b0;
                if (w_clr) begin
                    w_next = '0;
                end else if (w_inc && !w_dec) begin
                    if (r_cnt == c_max_count) w_ovf = 1'b1;
                    else                      w_next = r_cnt + 1'b1;
                end else if (w_dec && !w_inc) begin
                    if (r_cnt == '0) w_udf = 1'b1;
                    else             w_next = r_cnt - 1'b1;
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) r_cnt <= '0;
                else         r_cnt <= w_next;
            end

            assign r_count[g]      = r_cnt;
            assign w_count_next[g] = w_next;
            assign w_ovf_evt[g]    = w_ovf;
            assign w_udf_evt[g]    = w_udf;
        end
    endgenerate

    // A new error event in the same cycle as err_clr_i keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (|w_ovf_evt)         r_overflow  <= 1'b1;
            else if (bus.err_clr_i) r_overflow  <= 1'b0;
            if (|w_udf_evt)         r_underflow <= 1'b1;
            else if (bus.err_clr_i) r_underflow <= 1'b0;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD_PORTS_P; k++) begin : g_rd
            logic [LG_NUM_WAY_GROUPS_LP-1:0] w_idx;
            logic [WIDTH_P-1:0]              w_val;

            assign w_idx = bus.r_way_group_i[k*LG_NUM_WAY_GROUPS_LP +: LG_NUM_WAY_GROUPS_LP];

            // Mux by comparison so an out-of-range index reads as zero.
            always_comb begin
                w_val = '0;
                for (int g = 0; g < NUM_WAY_GROUPS_P; g++) begin
                    if (w_idx == LG_NUM_WAY_GROUPS_LP'(g)) begin
                        w_val = BYPASS_P ? w_count_next[g] : r_count[g];
                    end
                end
            end

            assign bus.count_o[k*WIDTH_P +: WIDTH_P] = w_val;
            assign bus.pending_o[k]                  = |w_val;
        end
    endgenerate

    assign bus.pending_v_o   = bus.r_v_i;
    assign bus.any_pending_o = |r_count;
    assign bus.overflow_o    = r_overflow;
    assign bus.underflow_o   = r_underflow;
endmodule
`default_nettype wire
